// File: rtl/nios2_system_sysid_checker_pkg.sv
// Shared types and constants for the sysid boot checker.
// State encoding and sysid word addresses.
package nios2_system_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_ID,
        RD_TS,
        DONE
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Full-width equality, no masking.
    function automatic logic word_match(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return a == b;
    endfunction

endpackage

// File: rtl/nios2_system_sysid_checker_if.sv
// Avalon-MM read-only link between the checker and sysid.
// Zero read latency; waitrequest stalls the transfer.
interface nios2_system_sysid_checker_if;

    logic        m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;

    modport master (
        output m_address,
        output m_read,
        input  m_waitrequest,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_read,
        output m_waitrequest,
        output m_readdata
    );

endinterface

// File: rtl/nios2_system_sysid_checker_wait_timer.sv
// Loadable saturating wait counter with clear/enable.
// expired is high while the count sits at LIMIT.
module nios2_system_wait_timer #(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned WIDTH = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_q;

    // Count up when enabled, stick at LIMIT; clear wins over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != LIM)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == LIM);

endmodule

// File: rtl/nios2_system_sysid_checker.sv
// Boot-time sysid checker: reads ID and timestamp words
// and compares them against build-time expected values.
module nios2_system_sysid_checker
    import nios2_system_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1620659088,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    nios2_system_sysid_checker_if.master  avm,
    output logic                          busy,
    output logic                          done,
    output logic                          id_ok,
    output logic                          ts_ok,
    output logic                          timeout_err,
    output logic [31:0]                   id_value,
    output logic [31:0]                   ts_value
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t state_q;
    state_t state_d;

    logic armed_q;
    logic in_rd;
    logic stall;
    logic xfer;
    logic expired;
    logic tmo;
    logic accept;

    assign in_rd  = (state_q == RD_ID) || (state_q == RD_TS);
    assign stall  = in_rd && avm.m_waitrequest;
    assign xfer   = in_rd && !avm.m_waitrequest;
    assign tmo    = stall && expired;
    assign accept = start && armed_q &&
                    ((state_q == IDLE) || (state_q == DONE));

    // Blocks a start on the very first edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    // Per-read stall counter; cleared on start and on each completion.
    nios2_system_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (CW)
    ) u_wait_timer (
        .clk      (clock),
        .rst_n    (reset_n),
        .clear    (accept || xfer),
        .en       (stall),
        .load     (1'b0),
        .load_val ({CW{1'b0}}),
        .expired  (expired)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) state_d = RD_ID;
            end
            RD_ID: begin
                if (xfer)     state_d = RD_TS;
                else if (tmo) state_d = DONE;
            end
            RD_TS: begin
                if (xfer || tmo) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture read data and flags; cleared when a run is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else if (accept) begin
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else if (xfer && (state_q == RD_ID)) begin
            id_value <= avm.m_readdata;
            id_ok    <= word_match(avm.m_readdata, EXPECTED_ID);
        end else if (xfer && (state_q == RD_TS)) begin
            ts_value <= avm.m_readdata;
            ts_ok    <= word_match(avm.m_readdata, EXPECTED_TIMESTAMP);
        end else if (tmo) begin
            timeout_err <= 1'b1;
        end
    end

    assign avm.m_read    = in_rd;
    assign avm.m_address = (state_q == RD_TS) ? SYSID_ADDR_TS
                                              : SYSID_ADDR_ID;
    assign busy          = in_rd;
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_nios2_system_sysid_checker.sv
// Directed bench for the sysid checker with a stallable
// sysid slave model; TIMEOUT_CYCLES is set to 4.
module tb_nios2_system_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1620659088;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;

    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout_err;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    logic [31:0] id_word  = 32'd0;
    logic [31:0] ts_word  = TS_GOOD;
    int          stall_id = 0;
    int          stall_ts = 0;
    int          scnt     = 0;

    int checks   = 0;
    int failures = 0;
    int lat;

    always #5 clock = ~clock;

    nios2_system_sysid_checker_if bus ();

    nios2_system_sysid_checker #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .avm         (bus),
        .busy        (busy),
        .done        (done),
        .id_ok       (id_ok),
        .ts_ok       (ts_ok),
        .timeout_err (timeout_err),
        .id_value    (id_value),
        .ts_value    (ts_value)
    );

    // Slave: stall the first N cycles of each read.
    assign bus.m_readdata    = bus.m_address ? ts_word : id_word;
    assign bus.m_waitrequest = bus.m_read &&
        (scnt < (bus.m_address ? stall_ts : stall_id));

    always @(posedge clock) begin
        if (bus.m_read && bus.m_waitrequest) scnt <= scnt + 1;
        else                                 scnt <= 0;
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pulse start, then count sampled cycles until done.
    task automatic run(output int n);
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!done) check("done_bound", 32'(done), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_read", 32'(bus.m_read), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_id", id_value, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // T1: zero-wait, exact cycle timing.
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        check("t1_rd1", 32'(bus.m_read), 1);
        check("t1_ad1", 32'(bus.m_address), 0);
        check("t1_busy", 32'(busy), 1);
        @(negedge clock);
        check("t1_rd2", 32'(bus.m_read), 1);
        check("t1_ad2", 32'(bus.m_address), 1);
        @(negedge clock);
        check("t1_done", 32'(done), 1);
        check("t1_rd3", 32'(bus.m_read), 0);
        check("t1_idok", 32'(id_ok), 1);
        check("t1_tsok", 32'(ts_ok), 1);
        check("t1_tmo", 32'(timeout_err), 0);
        check("t1_tsv", ts_value, TS_GOOD);

        // T2: wrong ID word.
        id_word = 32'h0000_0001;
        run(lat);
        check("t2_lat", lat, 3);
        check("t2_idok", 32'(id_ok), 0);
        check("t2_tsok", 32'(ts_ok), 1);
        check("t2_idv", id_value, 32'h1);

        // T2b: wrong timestamp word.
        id_word = 32'd0;
        ts_word = 32'hDEAD_BEEF;
        run(lat);
        check("t2b_idok", 32'(id_ok), 1);
        check("t2b_tsok", 32'(ts_ok), 0);
        check("t2b_tsv", ts_value, 32'hDEAD_BEEF);
        ts_word = TS_GOOD;

        // T3: three stall cycles on each read.
        stall_id = 3;
        stall_ts = 3;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) @(negedge clock);
            check($sformatf("t3_rd%0d", k), 32'(bus.m_read),
                  (k <= 8) ? 32'd1 : 32'd0);
            if (k <= 8)
                check($sformatf("t3_ad%0d", k), 32'(bus.m_address),
                      (k >= 5) ? 32'd1 : 32'd0);
        end
        check("t3_done", 32'(done), 1);
        check("t3_idok", 32'(id_ok), 1);
        check("t3_tsok", 32'(ts_ok), 1);

        // T4: timestamp read stuck, timeout after limit.
        stall_id = 0;
        stall_ts = 1000;
        run(lat);
        check("t4_lat", lat, 7);
        check("t4_tmo", 32'(timeout_err), 1);
        check("t4_rd", 32'(bus.m_read), 0);
        check("t4_idok", 32'(id_ok), 1);
        check("t4_tsok", 32'(ts_ok), 0);
        check("t4_tsv", ts_value, 0);
        stall_ts = 0;

        // T5: start during RD_TS is ignored.
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        check("t5_done", 32'(done), 1);
        @(negedge clock);
        check("t5_hold", 32'(done), 1);
        check("t5_rd", 32'(bus.m_read), 0);

        // T5b: rerun from DONE clears flags first.
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        check("t5b_done", 32'(done), 0);
        check("t5b_idok", 32'(id_ok), 0);
        check("t5b_tsv", ts_value, 0);
        check("t5b_busy", 32'(busy), 1);
        @(negedge clock);
        @(negedge clock);
        check("t5b_fin", 32'(done), 1);
        check("t5b_tsok", 32'(ts_ok), 1);

        // T6: async reset during stalled ID read.
        stall_id = 1000;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rd", 32'(bus.m_read), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_done", 32'(done), 0);
        check("t6_tsv", ts_value, 0);
        repeat (2) @(negedge clock);
        reset_n  = 1'b1;
        stall_id = 0;
        repeat (3) @(negedge clock);
        check("t6_idle", 32'(busy), 0);
        check("t6_idle_d", 32'(done), 0);
        run(lat);
        check("t6_lat", lat, 3);
        check("t6_ok", 32'(id_ok && ts_ok), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios2_system_sysid_checker.md
Name: nios2_system_sysid_checker

Overview:
Avalon-MM master that reads the system-ID slave at boot or on request. It fetches the ID word (address 0) and the timestamp word (address 1) and compares each against build-time expected values. It reports pass/fail/timeout status to the reset/boot sequencer and to debug LEDs. It sits on the same interconnect as the sysid control_slave and is that slave's initiator.

Parameters:
EXPECTED_ID, 32'd0, ID word the slave must return at address 0
EXPECTED_TIMESTAMP, 32'd1620659088, timestamp word the slave must return at address 1
TIMEOUT_CYCLES, 255, maximum consecutive waitrequest-high cycles per read before abort (1..65535)

Ports:
clock  input  1  system clock; all logic rising-edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to run a check sequence
m_address  output  1  Avalon word address to sysid (0 = ID, 1 = timestamp)
m_read  output  1  Avalon read strobe
m_waitrequest  input  1  slave stall; a transfer completes in a cycle with m_read=1 and m_waitrequest=0
m_readdata  input  32  read data, valid in the completing cycle (zero read latency)
busy  output  1  high while a sequence is in progress
done  output  1  high from sequence end until the next accepted start
id_ok  output  1  captured ID == EXPECTED_ID
ts_ok  output  1  captured timestamp == EXPECTED_TIMESTAMP
timeout_err  output  1  a read exceeded TIMEOUT_CYCLES
id_value  output  32  last captured ID word
ts_value  output  32  last captured timestamp word

Behaviour:
- Clock is `clock`; reset is `reset_n`, asynchronous, active-low. Reset forces state IDLE and all outputs and registers to 0, including mid-transfer; m_read drops immediately on reset assertion.
- States: IDLE, RD_ID, RD_TS, DONE.
- IDLE: start=1 -> RD_ID; clear id_ok, ts_ok, timeout_err, id_value, ts_value, done and the wait counter.
- RD_ID: m_read=1, m_address=0, busy=1. In the completing cycle, id_value<=m_readdata, id_ok<=(m_readdata==EXPECTED_ID), counter<=0, next state RD_TS.
- RD_TS: m_read=1, m_address=1, busy=1. In the completing cycle, ts_value<=m_readdata, ts_ok<=compare, next state DONE.
- m_read and m_address come from registered state and are held stable while m_waitrequest=1. m_read is never deasserted mid-transfer except by timeout or reset.
- With a zero-wait slave, m_read is high for exactly 2 cycles; done rises 3 cycles after the start cycle (start edge -> RD_ID -> RD_TS -> DONE).
- Timeout: a counter of width clog2(TIMEOUT_CYCLES+1) increments each RD_* cycle with m_waitrequest=1. When it equals TIMEOUT_CYCLES and waitrequest is still high, the next state is DONE with timeout_err=1 and m_read=0. Flags for the unfinished read stay 0. Values already captured are retained.
- DONE: done=1, busy=0, results held. start=1 -> RD_ID with clear, as in IDLE.
- start while busy=1 is ignored and not queued.
- start coinciding with reset deassertion edge: ignored (reset dominates).
- Comparison is full 32-bit equality; no masking.

Decomposition:
- Shared package nios2_system_pkg holds the state enum (IDLE, RD_ID, RD_TS, DONE) and the address constants SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1.
- One sub-module is natural: nios2_system_wait_timer, a loadable saturating counter with clear/enable and an expired flag, reused by other masters.
- FSM and capture registers stay in the top module.

Test Plan:
- Zero-wait slave returning 0 and 1620659088, start pulse at cycle 10 -> m_read high at cycles 11-12, done=1 at cycle 13, id_ok=1, ts_ok=1, timeout_err=0.
- Slave returning ID 32'h0000_0001 -> id_ok=0, ts_ok=1, id_value=1, done=1.
- waitrequest held high 3 cycles on each read -> m_read/m_address stable throughout, both values captured correctly, done 9 cycles after start.
- waitrequest stuck high on address 1, TIMEOUT_CYCLES=4 -> timeout_err=1 after 4 stalled cycles, m_read=0, id_ok=1, ts_ok=0, done=1.
- Second start pulse during RD_TS -> ignored; sequence completes once. A start in DONE reruns the sequence and clears flags for one cycle before new results.
- reset_n asserted low while in RD_ID with waitrequest high -> m_read=0 and all outputs 0 asynchronously; after release the FSM is in IDLE and waits for start.
